// File: rtl/spi_mem_loader_pkg.sv
// Shared definitions for the serial cache loader.
//   - Default cache geometry (word width, address width, valid entries per cache).
//   - FSM state encoding.
//   - Frame bit positions, counted in clocks from the first CS-low cycle (c0).
package spi_mem_loader_pkg;

   localparam int DATA_W  = 8;
   localparam int ADDR_W  = 4;
   localparam int IMEM_SZ = 16;
   localparam int DMEM_SZ = 15;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      COMMIT  = 2'd2,
      WAIT_CS = 2'd3
   } state_e;

   // Frame layout: c0 rw, c1..c4 addr, c5 turnaround / first data bit, c13 last.
   localparam logic [3:0] RW_BIT    = 4'd0;
   localparam logic [3:0] ADDR_LAST = 4'd4;
   localparam logic [3:0] TURN      = 4'd5;
   localparam logic [3:0] LAST      = 4'd13;

endpackage

// File: rtl/spi_mem_loader_bit_shifter.sv
// spi_bit_shifter: parallel-load / serial-shift register, MSB first.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   load_i         load load_data_i (has priority over shift_i)
//   load_data_i    parallel load value
//   shift_i        shift left by one, ser_i enters at bit 0
//   ser_i          serial input
//   par_o          register contents; par_o[WIDTH-1] is the serial output
module spi_bit_shifter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_data_i,
   input  logic             shift_i,
   input  logic             ser_i,
   output logic [WIDTH-1:0] par_o
);

   logic [WIDTH-1:0] data_q, data_d;

   always_comb begin
      // NOTE: default assignment first so every path drives data_d; no latch is inferred.
      data_d = data_q;
      if (load_i) begin
         data_d = load_data_i;
      end else if (shift_i) begin
         data_d = {data_q[WIDTH-2:0], ser_i};
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign par_o = data_q;

endmodule

// File: rtl/spi_mem_loader.sv
// spi_mem_loader: serial loader that owns the icache/dcache write and readback
// ports while the processor is stopped. sclk is clk; mosi sampled on rising clk.
// Ports:
//   csi_n_in / csd_n_in   icache / dcache chip selects (active low)
//   mosi_in               serial frame data, MSB first
//   proc_run_in           processor run enable; frames are refused or aborted while high
//   rdata_in              combinational read data of the selected cache at mem_addr_out
//   mem_addr_out          cache address, mem_wdata_out write data
//   icache_wen_out        one-cycle icache write strobe
//   dcache_wen_out        one-cycle dcache write strobe
//   mem_sel_out           frame target (0 icache, 1 dcache)
//   busy_out              loader owns the cache ports (state != IDLE)
//   miso_out              readback data, valid in read cycles c6..c13, 0 otherwise
//   frame_err_out         one-cycle pulse on an aborted or illegal frame
module spi_mem_loader #(
   parameter int DATA_W  = spi_mem_loader_pkg::DATA_W,
   parameter int ADDR_W  = spi_mem_loader_pkg::ADDR_W,
   parameter int DMEM_SZ = spi_mem_loader_pkg::DMEM_SZ
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              csi_n_in,
   input  logic              csd_n_in,
   input  logic              mosi_in,
   input  logic              proc_run_in,
   input  logic [DATA_W-1:0] rdata_in,
   output logic [ADDR_W-1:0] mem_addr_out,
   output logic [DATA_W-1:0] mem_wdata_out,
   output logic              icache_wen_out,
   output logic              dcache_wen_out,
   output logic              mem_sel_out,
   output logic              busy_out,
   output logic              miso_out,
   output logic              frame_err_out
);

   import spi_mem_loader_pkg::*;

   state_e            state_q;
   logic [3:0]        cnt_q;
   logic              rw_q, sel_q, rd_active_q;
   logic              iwen_q, dwen_q, err_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] shift_par;

   logic              own_cs_hi, other_cs_lo, abort, addr_valid;
   logic              shift_en, load_en;
   logic [DATA_W-1:0] load_data;

   always_comb begin
      own_cs_hi   = sel_q ? csd_n_in : csi_n_in;
      other_cs_lo = sel_q ? !csi_n_in : !csd_n_in;
      abort       = (state_q == SHIFT) && (own_cs_hi || other_cs_lo || proc_run_in);
      addr_valid  = sel_q ? (int'(addr_q) < DMEM_SZ) : (int'(addr_q) < IMEM_SZ);
      // Write frames shift data in on c5..c12; read frames load at the end of
      // c5 and then shift the readback out on c6..c12.
      shift_en    = 1'b0;
      load_en     = 1'b0;
      if (state_q == SHIFT && !abort) begin
         shift_en = rw_q ? (cnt_q >= TURN && cnt_q < LAST)
                         : (cnt_q >  TURN && cnt_q < LAST);
         load_en  = !rw_q && (cnt_q == TURN);
      end
      // Out-of-range dcache reads return zero rather than stale array contents.
      load_data   = addr_valid ? rdata_in : '0;
   end

   spi_bit_shifter #(.WIDTH(DATA_W)) u_shifter (
      .clk         (clk),
      .rst         (rst),
      .load_i      (load_en),
      .load_data_i (load_data),
      .shift_i     (shift_en),
      .ser_i       (mosi_in),
      .par_o       (shift_par)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rw_q        <= 1'b0;
         sel_q       <= 1'b0;
         rd_active_q <= 1'b0;
         iwen_q      <= 1'b0;
         dwen_q      <= 1'b0;
         err_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
      end else begin
         iwen_q <= 1'b0;
         dwen_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               // CS activity is ignored entirely while the processor runs.
               if (!proc_run_in) begin
                  if (!csi_n_in && !csd_n_in) begin
                     err_q   <= 1'b1;
                     state_q <= WAIT_CS;
                  end else if (csi_n_in != csd_n_in) begin
                     // This cycle is c0: it carries the rw bit.
                     sel_q   <= !csd_n_in;
                     rw_q    <= mosi_in;
                     cnt_q   <= RW_BIT + 4'd1;
                     state_q <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               if (abort) begin
                  err_q       <= 1'b1;
                  rd_active_q <= 1'b0;
                  cnt_q       <= '0;
                  state_q     <= WAIT_CS;
               end else begin
                  if (cnt_q != LAST) begin
                     cnt_q <= cnt_q + 4'd1;
                  end
                  if (cnt_q <= ADDR_LAST) begin
                     addr_q <= {addr_q[ADDR_W-2:0], mosi_in};
                  end
                  if (rw_q && cnt_q == LAST - 4'd1) begin
                     wdata_q <= {shift_par[DATA_W-2:0], mosi_in};
                     iwen_q  <= !sel_q;
                     dwen_q  <= sel_q && addr_valid;
                     state_q <= COMMIT;
                  end
                  if (!rw_q && cnt_q == TURN) begin
                     rd_active_q <= 1'b1;
                  end
                  if (!rw_q && cnt_q == LAST) begin
                     rd_active_q <= 1'b0;
                     cnt_q       <= '0;
                     state_q     <= WAIT_CS;
                  end
               end
            end
            COMMIT: begin
               cnt_q   <= '0;
               state_q <= WAIT_CS;
            end
            WAIT_CS: begin
               if (csi_n_in && csd_n_in) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_addr_out   = addr_q;
   assign mem_wdata_out  = wdata_q;
   assign icache_wen_out = iwen_q;
   assign dcache_wen_out = dwen_q;
   assign mem_sel_out    = sel_q;
   assign busy_out       = (state_q != IDLE);
   assign miso_out       = rd_active_q & shift_par[DATA_W-1];
   assign frame_err_out  = err_q;

endmodule

// File: tb/tb_spi_mem_loader.sv
module tb_spi_mem_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       csi_n, csd_n, mosi, proc_run;
   logic [7:0] rdata;
   logic [3:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       iwen, dwen, msel, busy, miso, ferr;

   logic [7:0] imem [16];
   logic [7:0] dmem [16];

   always #5 clk = ~clk;

   assign rdata = msel ? dmem[mem_addr] : imem[mem_addr];

   spi_mem_loader dut (
      .clk            (clk),
      .rst            (rst),
      .csi_n_in       (csi_n),
      .csd_n_in       (csd_n),
      .mosi_in        (mosi),
      .proc_run_in    (proc_run),
      .rdata_in       (rdata),
      .mem_addr_out   (mem_addr),
      .mem_wdata_out  (mem_wdata),
      .icache_wen_out (iwen),
      .dcache_wen_out (dwen),
      .mem_sel_out    (msel),
      .busy_out       (busy),
      .miso_out       (miso),
      .frame_err_out  (ferr)
   );

   typedef struct {
      bit         dc;
      logic [3:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t        wr_q[$];
   logic [7:0] rd_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 100;
   int         err_seen = 0;
   bit         reading  = 0;
   logic [7:0] miso_cap;
   logic [7:0] exp_byte;
   logic [13:0] rbits;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called #1 after each rising edge; cyc is the frame cycle just clocked.
   task automatic sample();
      int  cur;
      wr_t w;
      cur = cyc + 1;
      if (ferr === 1'b1) err_seen++;
      if (iwen === 1'b1 || dwen === 1'b1) begin
         check("wen_cycle", cur, 13);
         check("wen_expected", wr_q.size() > 0, 1);
         if (wr_q.size() > 0) begin
            w = wr_q.pop_front();
            check("wen_icache", iwen, !w.dc);
            check("wen_dcache", dwen, w.dc);
            check("wen_addr", mem_addr, w.addr);
            check("wen_data", mem_wdata, w.data);
         end
      end
      if (reading && cur >= 6 && cur <= 13) miso_cap = {miso_cap[6:0], miso};
      else check("miso_quiet", miso, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      sample();
   endtask

   task automatic idle(input int n);
      csi_n = 1'b1;
      csd_n = 1'b1;
      mosi  = 1'b0;
      cyc   = 100;
      repeat (n) tick();
   endtask

   // stop_at: cycle in which CS is raised early (-1 none).
   // run_at:  cycle from which proc_run is held high (-1 none).
   task automatic send_frame(input bit dc, input bit rw, input logic [3:0] addr,
                             input logic [7:0] data, input int stop_at, input int run_at);
      logic [13:0] bits;
      bit          normal;
      bits     = {rw, addr, data, 1'b0};
      normal   = (stop_at < 0) && (run_at < 0);
      reading  = normal && !rw;
      miso_cap = '0;
      for (int c = 0; c < 14; c++) begin
         if (c == stop_at) break;
         cyc      = c;
         csi_n    = dc;
         csd_n    = !dc;
         mosi     = bits[13-c];
         proc_run = (run_at >= 0) && (c >= run_at);
         tick();
         if (normal && c == 4) begin
            check("addr_c5", mem_addr, addr);
            check("sel_c5", msel, dc);
         end
         if (normal && c < 13) check("busy_in_frame", busy, 1);
         if (run_at == 0) check("busy_ignored", busy, 0);
      end
      cyc   = (stop_at >= 0) ? stop_at : 14;
      csi_n = 1'b1;
      csd_n = 1'b1;
      mosi  = 1'b0;
      tick();
      reading = 0;
      if (normal) check("busy_after_cs", busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 16; i++) begin
         imem[i] = 8'h10 + 8'(i);
         dmem[i] = 8'h80 | 8'(i);
      end
      dmem[2]  = 8'hC6;
      dmem[15] = 8'h5A;

      rst = 1'b1; csi_n = 1'b1; csd_n = 1'b1; mosi = 1'b0; proc_run = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_iwen", iwen, 0);
      check("rst_dwen", dwen, 0);
      check("rst_err", ferr, 0);
      check("rst_miso", miso, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_sel", msel, 0);
      rst = 1'b0;
      idle(2);

      // Write icache addr 5 <- A3
      err_seen = 0;
      wr_q.push_back('{dc: 1'b0, addr: 4'h5, data: 8'hA3});
      send_frame(1'b0, 1'b1, 4'h5, 8'hA3, -1, -1);
      idle(2);
      check("wr_icache_drained", wr_q.size(), 0);
      check("wr_icache_no_err", err_seen, 0);

      // Read dcache addr 2 (C6)
      rd_q.push_back(8'hC6);
      send_frame(1'b1, 1'b0, 4'h2, 8'h00, -1, -1);
      exp_byte = rd_q.pop_front();
      check("rd_dcache_miso", miso_cap, exp_byte);
      idle(2);

      // Invalid dcache address 0xF: write suppressed, readback zero, no error
      err_seen = 0;
      send_frame(1'b1, 1'b1, 4'hF, 8'hFF, -1, -1);
      idle(2);
      check("inv_wr_no_strobe", wr_q.size(), 0);
      rd_q.push_back(8'h00);
      send_frame(1'b1, 1'b0, 4'hF, 8'h00, -1, -1);
      exp_byte = rd_q.pop_front();
      check("inv_rd_miso", miso_cap, exp_byte);
      check("inv_no_err", err_seen, 0);
      idle(2);

      // Abort: csi raised in c8 of a write
      err_seen = 0;
      send_frame(1'b0, 1'b1, 4'h9, 8'h77, 8, -1);
      idle(2);
      check("abort_err_pulse", err_seen, 1);
      check("abort_idle", busy, 0);
      wr_q.push_back('{dc: 1'b1, addr: 4'h7, data: 8'h3C});
      send_frame(1'b1, 1'b1, 4'h7, 8'h3C, -1, -1);
      idle(2);
      check("after_abort_drained", wr_q.size(), 0);

      // Both CS low at frame start
      err_seen = 0;
      csi_n = 1'b0; csd_n = 1'b0; mosi = 1'b1; cyc = 0;
      tick();
      check("both_cs_busy", busy, 1);
      cyc = 100;
      repeat (2) tick();
      idle(3);
      check("both_cs_err", err_seen, 1);
      check("both_cs_idle", busy, 0);

      // proc_run rising at c3
      err_seen = 0;
      send_frame(1'b1, 1'b1, 4'h3, 8'h55, -1, 3);
      proc_run = 1'b0;
      idle(2);
      check("run_abort_err", err_seen, 1);
      check("run_abort_idle", busy, 0);

      // proc_run high before CS low: ignored
      err_seen = 0;
      send_frame(1'b0, 1'b1, 4'h4, 8'h99, -1, 0);
      proc_run = 1'b0;
      idle(2);
      check("run_ignored_err", err_seen, 0);

      // Async reset during c9 of a write
      err_seen = 0;
      rbits = {1'b1, 4'h6, 8'hE7, 1'b0};
      for (int c = 0; c < 9; c++) begin
         cyc = c; csi_n = 1'b0; csd_n = 1'b1; mosi = rbits[13-c];
         tick();
      end
      cyc = 9; mosi = rbits[4];
      #2 rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_iwen", iwen, 0);
      check("arst_dwen", dwen, 0);
      check("arst_err", ferr, 0);
      check("arst_addr", mem_addr, 0);
      check("arst_wdata", mem_wdata, 0);
      check("arst_sel", msel, 0);
      check("arst_miso", miso, 0);
      #2 rst = 1'b0;
      idle(3);
      check("arst_no_err", err_seen, 0);
      wr_q.push_back('{dc: 1'b0, addr: 4'h0, data: 8'h01});
      send_frame(1'b0, 1'b1, 4'h0, 8'h01, -1, -1);
      idle(2);
      check("arst_next_drained", wr_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
